// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM plus a 16-word MMIO window (LED, cycle counter, status).
// Optional feature macro: DMEM_CYCLE_COUNTER_EN adds the free-running cycle counter at MMIO offset 1.
module dmem_responder #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [31:0] MMIO_BASE = 32'h0000_F000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] led_out,
    output logic        bus_error
);

    localparam int unsigned RAM_WORDS = 1 << ADDR_BITS;

    logic [31:0]          ram_r [RAM_WORDS];
    logic                 is_ram_s;
    logic                 is_mmio_s;
    logic                 is_unmapped_s;
    logic [3:0]           offset_s;
    logic [ADDR_BITS-1:0] ram_idx_s;
    logic                 ram_we_s;
    logic                 led_we_s;
    logic                 err_set_s;
    logic                 err_clr_s;
    logic [31:0]          rdata_s;

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0]          cycle_count_r;
`endif

    // Region decode and store qualification; RAM wins if the windows ever overlap.
    always_comb begin
        is_ram_s      = ((address_dmem >> ADDR_BITS) == 32'd0);
        is_mmio_s     = 1'b0;
        is_unmapped_s = 1'b0;
        offset_s      = address_dmem[3:0];
        ram_idx_s     = address_dmem[ADDR_BITS-1:0];
        if (is_ram_s) begin
            is_mmio_s     = 1'b0;
            is_unmapped_s = 1'b0;
        end else if (address_dmem[31:4] == MMIO_BASE[31:4]) begin
            is_mmio_s     = 1'b1;
            is_unmapped_s = 1'b0;
        end else begin
            is_mmio_s     = 1'b0;
            is_unmapped_s = 1'b1;
        end
        ram_we_s  = wren && is_ram_s && !reset;
        led_we_s  = wren && is_mmio_s && (offset_s == 4'd0) && !reset;
        err_set_s = wren && is_unmapped_s && !reset;
        err_clr_s = wren && is_mmio_s && (offset_s == 4'd2) && data[0] && !reset;
    end

    // Read-data mux; stores in the same cycle are forwarded (write-first).
    always_comb begin
        rdata_s = 32'd0;
        if (is_ram_s) begin
            rdata_s = ram_we_s ? data : ram_r[ram_idx_s];
        end else if (is_mmio_s) begin
            case (offset_s)
                4'd0:    rdata_s = led_we_s ? data : led_out;
`ifdef DMEM_CYCLE_COUNTER_EN
                4'd1:    rdata_s = cycle_count_r;
`else
                4'd1:    rdata_s = 32'd0;
`endif
                4'd2:    rdata_s = {31'd0, bus_error};
                default: rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    // RAM array: contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= data;
        end
    end

    // Registered load data, LED register and sticky bus-error flag (set wins over clear).
    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem    <= 32'd0;
            led_out   <= 32'd0;
            bus_error <= 1'b0;
        end else begin
            q_dmem    <= rdata_s;
            if (led_we_s) begin
                led_out <= data;
            end
            bus_error <= err_set_s | (bus_error & ~err_clr_s);
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count_r <= 32'd0;
        end else begin
            cycle_count_r <= cycle_count_r + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_dmem = 32'd0;
    logic [31:0] data = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic [31:0] led_out;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    dmem_responder dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .led_out      (led_out),
        .bus_error    (bus_error)
    );

    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Present one bus cycle, then return 1 time unit after the rising edge.
    task automatic step(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
        address_dmem = addr;
        data         = wdata;
        wren         = we;
        @(posedge clock);
        #1;
        wren = 1'b0;
    endtask

    logic [31:0] exp_count;

    initial begin
        // Reset state
        reset = 1'b1;
        step(32'd0, 32'd0, 1'b0);
        step(32'd0, 32'd0, 1'b0);
        check_value("reset_q", q_dmem, 32'd0);
        check_value("reset_led", led_out, 32'd0);
        check_value("reset_err", {31'd0, bus_error}, 32'd0);
        reset = 1'b0;

        // RAM store then load
        step(32'd5, 32'hDEAD_BEEF, 1'b1);
        step(32'd5, 32'd0, 1'b0);
        check_value("ram5_read", q_dmem, 32'hDEAD_BEEF);

        // Write-first on same address
        step(32'd7, 32'h0000_1234, 1'b1);
        check_value("ram7_wfirst", q_dmem, 32'h0000_1234);
        step(32'd7, 32'd0, 1'b0);
        check_value("ram7_read", q_dmem, 32'h0000_1234);

        // LED register
        step(32'h0000_F000, 32'h0000_00A5, 1'b1);
        check_value("led_store", led_out, 32'h0000_00A5);
        step(32'h0000_F000, 32'd0, 1'b0);
        check_value("led_read", q_dmem, 32'h0000_00A5);

        // Reserved MMIO offset: reads 0, store ignored without error
        step(32'd3, 32'h0000_0011, 1'b1);
        step(32'd0, 32'h0000_CAFE, 1'b1);
        step(32'h0000_F005, 32'h0000_0077, 1'b1);
        check_value("mmio5_q", q_dmem, 32'd0);
        check_value("mmio5_err", {31'd0, bus_error}, 32'd0);

        // Unmapped store sets sticky error and leaves RAM[0] intact
        step(32'h0010_0000, 32'h0000_0099, 1'b1);
        check_value("unmap_err", {31'd0, bus_error}, 32'd1);
        check_value("unmap_store_q", q_dmem, 32'd0);
        step(32'd0, 32'd0, 1'b0);
        check_value("ram0_intact", q_dmem, 32'h0000_CAFE);
        step(32'h0010_0000, 32'd0, 1'b0);
        check_value("unmap_read_q", q_dmem, 32'd0);
        check_value("err_sticky", {31'd0, bus_error}, 32'd1);
        step(32'h0000_F002, 32'd0, 1'b0);
        check_value("status_read", q_dmem, 32'd1);

        // Clear via status store
        step(32'h0000_F002, 32'd1, 1'b1);
        check_value("err_clear", {31'd0, bus_error}, 32'd0);
        step(32'h0000_F002, 32'd0, 1'b0);
        check_value("status_clr_read", q_dmem, 32'd0);
        check_value("led_held", led_out, 32'h0000_00A5);

        // Reset during a store: store suppressed, outputs cleared
        reset = 1'b1;
        step(32'd3, 32'h0000_0055, 1'b1);
        check_value("rst_store_q", q_dmem, 32'd0);
        check_value("rst_led", led_out, 32'd0);
        check_value("rst_err", {31'd0, bus_error}, 32'd0);
        reset = 1'b0;

        // Ten cycles after release, including a read of RAM[3]
        step(32'd3, 32'd0, 1'b0);
        check_value("ram3_kept", q_dmem, 32'h0000_0011);
        for (int i = 0; i < 9; i++) begin
            step(32'd0, 32'd0, 1'b0);
        end
        step(32'h0000_F001, 32'd0, 1'b0);
`ifdef DMEM_CYCLE_COUNTER_EN
        exp_count = 32'd10;
`else
        exp_count = 32'd0;
`endif
        check_value("counter_read", q_dmem, exp_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12: RAM depth is 2^ADDR_BITS 32-bit words, word-addressed.
REQ-002 SHALL have parameter MMIO_BASE, default 32'h0000_F000: base address of a 16-word peripheral window, matched on bits [31:4].
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port address_dmem, input, 32 bits: word address from the processor, presented every cycle.
REQ-006 SHALL have port data, input, 32 bits: store data.
REQ-007 SHALL have port wren, input, 1 bit: store enable.
REQ-008 SHALL have port q_dmem, output, 32 bits: registered load data.
REQ-009 SHALL have port led_out, output, 32 bits: value of the LED register.
REQ-010 SHALL have port bus_error, output, 1 bit: sticky flag for an unmapped store.

Function
REQ-011 SHALL decode the address into three regions; address < 2^ADDR_BITS is RAM; address[31:4]==MMIO_BASE[31:4] is MMIO; anything else is unmapped.
REQ-012 SHALL return read data at latency 1; q_dmem after rising edge N reflects address_dmem sampled at edge N.
REQ-013 SHALL write data to RAM[address] at the edge where wren=1 and the address is RAM.
REQ-014 SHALL be write-first; a read of the address being written in the same cycle returns the new data.
REQ-015 SHALL implement MMIO offset 0 as the LED register, read/write; a store updates led_out at the same edge.
REQ-016 SHALL implement MMIO offset 1 as the 32-bit cycle counter, read-only; stores are ignored.
REQ-017 SHALL increment the cycle counter every cycle when not in reset; 0xFFFF_FFFF wraps to 0.
REQ-018 SHALL implement MMIO offset 2 as status, with bit0 = bus_error and other bits = 0; a store with data[0]=1 clears bus_error.
REQ-019 SHALL treat MMIO offsets 3-15 as read 0, with stores ignored and no error.
REQ-020 SHALL treat an unmapped read as returning 0 with no error, because the processor presents an address every cycle.
REQ-021 SHALL on an unmapped store drop the write and set bus_error at that edge; bus_error stays set until cleared or reset.
REQ-022 SHALL let set win when a clear of bus_error and a new unmapped store occur in the same cycle; this cannot arise from one port, but it applies to future multi-port use.
REQ-023 SHALL return the counter value before the increment when offset 1 is read.

Reset
REQ-024 SHALL on reset drive q_dmem=0, led_out=0, counter=0 and bus_error=0 at the next edge.
REQ-025 SHALL suppress any RAM or MMIO store in a cycle where reset=1.
REQ-026 SHALL leave RAM contents unchanged by reset.
REQ-027 SHALL have counter=1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL gate the counter with the macro DMEM_CYCLE_COUNTER_EN; when defined, the counter is implemented per REQ-016/017.
REQ-029 SHALL, when DMEM_CYCLE_COUNTER_EN is undefined, have no counter flops and offset 1 reads 0; all other behaviour is unchanged.

Verification
REQ-030 SHALL pass: store 0xDEADBEEF to addr 5, then read addr 5 -> q_dmem=0xDEADBEEF one cycle after the read address.
REQ-031 SHALL pass: store 0x1234 to addr 7 while reading addr 7 -> q_dmem=0x1234 the next cycle (write-first).
REQ-032 SHALL pass: store 0xA5 to 0xF000 -> led_out=0xA5 after the edge; read 0xF000 -> 0xA5; reset -> led_out=0.
REQ-033 SHALL pass: store to 0x0010_0000 -> bus_error=1, RAM unchanged; read 0xF002 -> 1; store 1 to 0xF002 -> bus_error=0.
REQ-034 SHALL pass: release reset, wait 10 cycles, read 0xF001 -> counter value consistent with REQ-027; with the macro undefined -> 0.
REQ-035 SHALL pass: assert reset during a store of 0x55 to addr 3 -> RAM[3] keeps its prior value, q_dmem=0.
